// File: rtl/lsu.sv
// Load/store unit: one outstanding access, valid/ready toward the pipeline.
// Define LSU_MISALIGN_EN to fault misaligned H/HU/W accesses instead of ignoring the low address bits.
module lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  size_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wen_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_reg_wen_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP,
    DONE
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_result;
  logic [2:0]    r_size;
  logic          r_we;
  logic          r_re;
  logic          r_mem;
  logic          r_fault;
  logic [4:0]    r_rd;
  logic          r_wen;
  logic          r_res_wen;
  logic [CW-1:0] r_cnt;

  logic          w_acc;
  logic          w_in_mem;
  logic          w_in_ill;
  logic          w_in_mis;
  logic          w_bus;
  logic          w_load;
  logic          w_tmo;
  logic [1:0]    w_sh;
  logic [31:0]   w_shifted;
  logic [31:0]   w_ldata;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;

  assign w_acc    = req_valid_i && (r_state == IDLE);
  assign w_in_mem = we_i || re_i;
  assign w_in_ill = (size_i == 3'b011) || (size_i[2] && size_i[1]);

  // Misalignment check only exists when the fault option is built in.
`ifdef LSU_MISALIGN_EN
  always_comb begin
    w_in_mis = 1'b0;
    if (size_i[1:0] == 2'b01) w_in_mis = addr_i[0];
    if (size_i == 3'b010)     w_in_mis = |addr_i[1:0];
  end
`else
  assign w_in_mis = 1'b0;
`endif

  // Faulting requests still pass through ADDR, but never touch the bus.
  assign w_bus  = r_mem && !r_fault;
  assign w_load = r_re && !r_we;
  assign w_tmo  = (r_state == RESP) && !dbus_rvalid_i
               && (r_cnt == TMO_LAST);

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (req_valid_i) w_next = ADDR;
      ADDR: begin
        if (!w_bus)          w_next = DONE;
        else if (dbus_gnt_i) w_next = w_load ? RESP : DONE;
      end
      RESP: if (dbus_rvalid_i || w_tmo) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Response wait counter, cleared outside RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (r_state == RESP)   r_cnt <= r_cnt + 1'b1;
    else                        r_cnt <= '0;
  end

  // Request capture and result/fault bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_size    <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_mem     <= 1'b0;
      r_fault   <= 1'b0;
      r_rd      <= '0;
      r_wen     <= 1'b0;
      r_result  <= '0;
      r_res_wen <= 1'b0;
    end else if (w_acc) begin
      r_addr    <= addr_i;
      r_wdata   <= wdata_i;
      r_size    <= size_i;
      r_we      <= we_i;
      r_re      <= re_i;
      r_mem     <= w_in_mem;
      r_fault   <= w_in_mem && (w_in_ill || w_in_mis);
      r_rd      <= rd_addr_i;
      r_wen     <= reg_wen_i;
      r_result  <= w_in_mem ? 32'd0 : addr_i;
      r_res_wen <= w_in_mem ? 1'b0 : reg_wen_i;
    end else if (r_state == RESP) begin
      if (dbus_rvalid_i) begin
        r_result  <= w_ldata;
        r_res_wen <= r_wen && (r_rd != 5'd0);
      end else if (w_tmo) begin
        r_fault   <= 1'b1;
      end
    end
  end

  // Lane selection: bytes use both low bits, halves only bit 1.
  always_comb begin
    w_sh = 2'b00;
    unique case (r_size[1:0])
      2'b00:   w_sh = r_addr[1:0];
      2'b01:   w_sh = {r_addr[1], 1'b0};
      default: w_sh = 2'b00;
    endcase
  end

  assign w_shifted = dbus_rdata_i >> {w_sh, 3'b000};

  // Load extension.
  always_comb begin
    w_ldata = w_shifted;
    unique case (r_size)
      3'b000:  w_ldata = {{24{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_ldata = {24'd0, w_shifted[7:0]};
      3'b101:  w_ldata = {16'd0, w_shifted[15:0]};
      default: w_ldata = w_shifted;
    endcase
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = r_wdata;
    unique case (r_size[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // Moore outputs, all zero in IDLE so reset leaves only ready high.
  always_comb begin
    req_ready_o  = (r_state == IDLE);
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_be_o    = '0;
    dbus_wdata_o = '0;
    wb_valid_o   = 1'b0;
    wb_reg_wen_o = 1'b0;
    wb_rd_addr_o = '0;
    wb_data_o    = '0;
    fault_o      = 1'b0;
    if (r_state == ADDR && w_bus) begin
      dbus_req_o   = 1'b1;
      dbus_we_o    = r_we;
      dbus_addr_o  = {r_addr[31:2], 2'b00};
      dbus_be_o    = w_be;
      dbus_wdata_o = w_wdata;
    end
    if (r_state == DONE) begin
      wb_valid_o   = 1'b1;
      wb_reg_wen_o = r_res_wen && !r_fault;
      wb_rd_addr_o = r_rd;
      wb_data_o    = r_result;
      fault_o      = r_fault;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table plus reset and timeout sequences.
// Bus responder grants/returns data after per-vector delays.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [2:0]  size_i = '0;
  logic        we_i = 1'b0;
  logic        re_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic        reg_wen_i = 1'b0;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i = 1'b0;
  logic        dbus_rvalid_i = 1'b0;
  logic [31:0] dbus_rdata_i = '0;
  logic        wb_valid_o;
  logic        wb_reg_wen_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        fault_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .addr_i(addr_i), .wdata_i(wdata_i), .size_i(size_i),
    .we_i(we_i), .re_i(re_i),
    .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o),
    .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i(dbus_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_reg_wen_o(wb_reg_wen_o),
    .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
    .fault_o(fault_o)
  );

  typedef struct {
    string       nm;
    logic        re;
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdt;
    int          gd;
    int          rv;
    logic [4:0]  rd;
    logic        wen;
    logic        nb;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] wbd;
    logic        wbw;
    logic        flt;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(
    string nm, logic re, logic we, logic [2:0] sz,
    logic [31:0] a, logic [31:0] wd, logic [31:0] rdt,
    int gd, int rv, logic [4:0] rd, logic wen,
    logic nb, logic [3:0] be, logic [31:0] bwd,
    logic [31:0] wbd, logic wbw, logic flt, int lat);
    vec_t v;
    v.nm = nm; v.re = re; v.we = we; v.sz = sz;
    v.a = a; v.wd = wd; v.rdt = rdt;
    v.gd = gd; v.rv = rv; v.rd = rd; v.wen = wen;
    v.nb = nb; v.be = be; v.bwd = bwd;
    v.wbd = wbd; v.wbw = wbw; v.flt = flt; v.lat = lat;
    return v;
  endfunction

  task automatic run(input vec_t t);
    int n;
    int reqc;
    int rcnt;
    bit resp;
    bit done;
    bit stable;
    logic [31:0] f_addr;
    logic [31:0] f_wd;
    logic [3:0]  f_be;
    logic        f_we;
    @(negedge clk);
    chk({t.nm, " ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    re_i = t.re; we_i = t.we; size_i = t.sz;
    addr_i = t.a; wdata_i = t.wd;
    rd_addr_i = t.rd; reg_wen_i = t.wen;
    @(negedge clk);
    req_valid_i = 1'b0;
    re_i = 1'b0; we_i = 1'b0;
    addr_i = 32'hFFFF_FFFF; wdata_i = 32'h0;
    rd_addr_i = 5'd31; reg_wen_i = 1'b0;
    n = 1; reqc = 0; rcnt = 0;
    resp = 0; done = 0; stable = 1;
    f_addr = '0; f_wd = '0; f_be = '0; f_we = 1'b0;
    while (!done && n < 40) begin
      dbus_gnt_i = 1'b0;
      dbus_rvalid_i = 1'b0;
      dbus_rdata_i = 32'h5A5A_5A5A;
      if (wb_valid_o) begin
        done = 1;
        chk({t.nm, " latency"}, 32'(n), 32'(t.lat));
        chk({t.nm, " fault"}, 32'(fault_o), 32'(t.flt));
        chk({t.nm, " wb_wen"}, 32'(wb_reg_wen_o), 32'(t.wbw));
        chk({t.nm, " wb_rd"}, 32'(wb_rd_addr_o), 32'(t.rd));
        if (!t.we && !t.flt)
          chk({t.nm, " wb_data"}, wb_data_o, t.wbd);
        // late data in DONE must not disturb anything
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i = 32'h0BAD_0BAD;
      end else begin
        if (dbus_req_o) begin
          if (reqc == 0) begin
            f_addr = dbus_addr_o; f_wd = dbus_wdata_o;
            f_be = dbus_be_o; f_we = dbus_we_o;
            chk({t.nm, " bus_addr"}, dbus_addr_o, {t.a[31:2], 2'b00});
            chk({t.nm, " bus_be"}, 32'(dbus_be_o), 32'(t.be));
            chk({t.nm, " bus_we"}, 32'(dbus_we_o), 32'(t.we));
            chk({t.nm, " bus_wdata"}, dbus_wdata_o, t.bwd);
          end else if (dbus_addr_o !== f_addr || dbus_wdata_o !== f_wd
                       || dbus_be_o !== f_be || dbus_we_o !== f_we) begin
            stable = 0;
          end
          if (reqc == t.gd) begin
            dbus_gnt_i = 1'b1;
            if (t.re && !t.we) resp = 1;
          end
          reqc++;
        end else if (resp) begin
          if (rcnt == t.rv) begin
            dbus_rvalid_i = 1'b1;
            dbus_rdata_i = t.rdt;
          end
          rcnt++;
        end
        @(negedge clk);
        n++;
      end
    end
    if (!done) chk({t.nm, " wb_valid seen"}, 32'd0, 32'd1);
    chk({t.nm, " req cycles"}, 32'(reqc), t.nb ? 32'd0 : 32'(t.gd + 1));
    chk({t.nm, " bus stable"}, 32'(stable), 32'd1);
    @(negedge clk);
    dbus_rvalid_i = 1'b0;
    chk({t.nm, " wb pulse end"}, 32'(wb_valid_o), 32'd0);
    chk({t.nm, " ready back"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    vt.push_back(mk("lw104", 1, 0, 3'b010, 32'h104, 0, 32'hDEADBEEF, 0, 1, 5, 1,
                    0, 4'hF, 0, 32'hDEADBEEF, 1, 0, 4));
    vt.push_back(mk("lb203", 1, 0, 3'b000, 32'h203, 0, 32'h80FF0000, 0, 0, 6, 1,
                    0, 4'h8, 0, 32'hFFFFFF80, 1, 0, 3));
    vt.push_back(mk("lbu203", 1, 0, 3'b100, 32'h203, 0, 32'h80FF0000, 0, 0, 6, 1,
                    0, 4'h8, 0, 32'h00000080, 1, 0, 3));
    vt.push_back(mk("sh302", 0, 1, 3'b001, 32'h302, 32'h1234ABCD, 0, 3, 0, 7, 1,
                    0, 4'hC, 32'hABCDABCD, 0, 0, 0, 5));
    vt.push_back(mk("pass1", 0, 0, 3'b010, 32'hCAFE0001, 0, 0, 0, 0, 7, 1,
                    1, 0, 0, 32'hCAFE0001, 1, 0, 2));
    vt.push_back(mk("pass0", 0, 0, 3'b000, 32'h10, 0, 0, 0, 0, 9, 0,
                    1, 0, 0, 32'h10, 0, 0, 2));
    vt.push_back(mk("lh002", 1, 0, 3'b001, 32'h2, 0, 32'h80017FFF, 1, 0, 3, 1,
                    0, 4'hC, 0, 32'hFFFF8001, 1, 0, 4));
    vt.push_back(mk("lhu002", 1, 0, 3'b101, 32'h2, 0, 32'h80017FFF, 1, 0, 3, 1,
                    0, 4'hC, 0, 32'h00008001, 1, 0, 4));
    vt.push_back(mk("lh000", 1, 0, 3'b001, 32'h0, 0, 32'hFFFF7FFF, 0, 0, 3, 1,
                    0, 4'h3, 0, 32'h00007FFF, 1, 0, 3));
    vt.push_back(mk("lw_x0", 1, 0, 3'b010, 32'h8, 0, 32'h12345678, 0, 2, 0, 1,
                    0, 4'hF, 0, 32'h12345678, 0, 0, 5));
    vt.push_back(mk("sb011", 0, 1, 3'b000, 32'h11, 32'h000000A5, 0, 1, 0, 4, 1,
                    0, 4'h2, 32'hA5A5A5A5, 0, 0, 0, 3));
    vt.push_back(mk("sw020", 0, 1, 3'b010, 32'h20, 32'h01234567, 0, 0, 0, 4, 1,
                    0, 4'hF, 32'h01234567, 0, 0, 0, 2));
    vt.push_back(mk("ill011", 1, 0, 3'b011, 32'h40, 0, 0, 0, 0, 3, 1,
                    1, 0, 0, 0, 0, 1, 2));
    vt.push_back(mk("ill111", 0, 1, 3'b111, 32'h44, 32'h1, 0, 0, 0, 3, 1,
                    1, 0, 0, 0, 0, 1, 2));
    vt.push_back(mk("timeout", 1, 0, 3'b010, 32'h50, 0, 0, 0, -1, 3, 1,
                    0, 4'hF, 0, 0, 0, 1, 18));
`ifdef LSU_MISALIGN_EN
    vt.push_back(mk("lw101", 1, 0, 3'b010, 32'h101, 0, 32'h11223344, 0, 0, 8, 1,
                    1, 0, 0, 0, 0, 1, 2));
    vt.push_back(mk("lh003", 1, 0, 3'b001, 32'h3, 0, 32'hABCD0000, 0, 0, 8, 1,
                    1, 0, 0, 0, 0, 1, 2));
`else
    vt.push_back(mk("lw101", 1, 0, 3'b010, 32'h101, 0, 32'h11223344, 0, 0, 8, 1,
                    0, 4'hF, 0, 32'h11223344, 1, 0, 3));
    vt.push_back(mk("lh003", 1, 0, 3'b001, 32'h3, 0, 32'hABCD0000, 0, 0, 8, 1,
                    0, 4'hC, 0, 32'hFFFFABCD, 1, 0, 3));
`endif

    // Reset values
    #12;
    chk("rst ready", 32'(req_ready_o), 32'd1);
    chk("rst outs", {dbus_req_o, dbus_we_o, wb_valid_o, wb_reg_wen_o, fault_o},
        32'd0);
    chk("rst buses", dbus_addr_o | dbus_wdata_o | wb_data_o
        | 32'(dbus_be_o) | 32'(wb_rd_addr_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) run(vt[i]);

    // Reset while waiting for grant in ADDR
    @(negedge clk);
    req_valid_i = 1'b1; re_i = 1'b1; size_i = 3'b010;
    addr_i = 32'h600; rd_addr_i = 5'd2; reg_wen_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0; re_i = 1'b0;
    chk("arst pre req", 32'(dbus_req_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst req drop", 32'(dbus_req_o), 32'd0);
    chk("arst ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dbus_gnt_i = 1'b1;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i = 32'h7777_7777;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arst no wb", {wb_valid_o, fault_o, dbus_req_o}, 32'd0);
    end
    dbus_gnt_i = 1'b0;
    dbus_rvalid_i = 1'b0;

    // Back-to-back passthrough after the reset
    run(vt[4]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max cycles waiting for dbus_rvalid_i after grant before fault.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid_i  input  1  request from pipeline valid.
REQ-005 SHALL have port: req_ready_o  output  1  LSU can accept a request; pipeline stalls while low.
REQ-006 SHALL have port: addr_i  input  32  byte address for loads and stores, or ALU result passthrough.
REQ-007 SHALL have port: wdata_i  input  32  store data, low-lane aligned.
REQ-008 SHALL have port: size_i  input  3  funct3 access code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port: we_i / re_i  input  1 each  store / load request.
REQ-010 SHALL have port: rd_addr_i  input  5  destination register.
REQ-011 SHALL have port: reg_wen_i  input  1  destination write enable.
REQ-012 SHALL have port: dbus_req_o, dbus_we_o  output  1 each  bus request, bus write.
REQ-013 SHALL have port: dbus_addr_o  output  32  word-aligned bus address (bits [1:0]=00).
REQ-014 SHALL have port: dbus_be_o  output  4  byte enables.
REQ-015 SHALL have port: dbus_wdata_o  output  32  lane-replicated write data.
REQ-016 SHALL have port: dbus_gnt_i, dbus_rvalid_i  input  1 each  grant, read data valid.
REQ-017 SHALL have port: dbus_rdata_i  input  32  read data.
REQ-018 SHALL have port: wb_valid_o, wb_reg_wen_o  output  1 each  result valid pulse, register write enable.
REQ-019 SHALL have port: wb_rd_addr_o  output  5  destination register.
REQ-020 SHALL have port: wb_data_o  output  32  result.
REQ-021 SHALL have port: fault_o  output  1  one-cycle access-fault pulse.

Function
REQ-022 SHALL use FSM states IDLE, ADDR, RESP, DONE; req_ready_o SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid_i && req_ready_o.
REQ-023 SHALL register the accepted request, then behave as follows:
- we_i=re_i=0: go to DONE; wb_data_o=addr_i, wb_reg_wen_o=reg_wen_i.
- Otherwise: go to ADDR and assert dbus_req_o with stable addr/be/wdata/we until dbus_gnt_i.
REQ-024 On grant in ADDR, a store SHALL go to DONE and a load SHALL go to RESP; data arriving with dbus_rvalid_i in RESP SHALL be captured and the FSM SHALL go to DONE.
REQ-025 In DONE, wb_valid_o SHALL pulse for exactly one cycle and the FSM SHALL return to IDLE.
REQ-026 Latency SHALL be: passthrough, accept T -> wb_valid_o at T+2; store with same-cycle grant -> wb_valid_o at T+2; load with rvalid at T+k -> wb_valid_o at T+k+1.
REQ-027 dbus_be_o SHALL be:
- B/BU: 0001<<addr[1:0].
- H/HU: 0011<<(2*addr[1]).
- W: 1111.
REQ-028 dbus_wdata_o SHALL replicate the byte to all 4 lanes (B) and the half to both halves (H).
REQ-029 Load data SHALL be dbus_rdata_i shifted right by 8*addr[1:0], sign-extended for B/H and zero-extended for BU/HU; a store SHALL give wb_reg_wen_o=0; a load SHALL give wb_reg_wen_o = reg_wen_i && rd_addr_i!=0.
REQ-030 An illegal size code (011/110/111) on a memory request SHALL cause no bus access, a fault_o pulse, and DONE with wb_reg_wen_o=0.
REQ-031 A counter in RESP SHALL trigger when it reaches TIMEOUT without rvalid: fault_o pulse, DONE with wb_reg_wen_o=0, and any late rvalid SHALL be ignored.
REQ-032 fault_o SHALL be coincident with the wb_valid_o pulse of the faulting request.

Reset
REQ-033 While rst_n=0, all outputs SHALL be 0 except req_ready_o=1, with state IDLE and the timeout counter at 0.
REQ-034 Reset mid-transaction SHALL drop dbus_req_o immediately (asynchronously), abandon the access, and produce no wb_valid_o.

Configuration
REQ-035 With LSU_MISALIGN_EN defined, H/HU with addr[0]=1 or W with addr[1:0]!=0 SHALL cause no bus access, a fault_o pulse, and DONE with wb_reg_wen_o=0.
REQ-036 With LSU_MISALIGN_EN undefined, the misaligned low address bits SHALL be ignored (H uses addr[1] only, W uses be 1111) and fault_o SHALL never assert for misalignment.

Verification
REQ-037 LW addr 0x104, grant at T+1, rvalid with 0xDEADBEEF at T+3 -> wb_valid_o at T+4, wb_data_o=0xDEADBEEF, be=1111.
REQ-038 LB addr 0x203, rdata 0x80FF_0000 -> be=1000, wb_data_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-039 SH addr 0x302 wdata 0x1234ABCD, grant held low 3 cycles -> dbus_req_o and signals stable for 4 cycles, be=1100, wdata=0xABCDABCD, wb_reg_wen_o=0.
REQ-040 Load granted, rvalid never arrives -> fault_o and wb_valid_o pulse after TIMEOUT=16 cycles in RESP, req_ready_o back to 1 next cycle.
REQ-041 LW addr 0x101 -> with LSU_MISALIGN_EN: fault, no dbus_req_o; without: bus addr 0x100, be=1111, normal completion.
REQ-042 rst_n low while in ADDR -> dbus_req_o=0 same cycle, req_ready_o=1, no wb_valid_o after release.
